// File: rtl/seg7_result_display.sv
// seg7_result_display: converts a 20-bit binary result to six BCD digits with
// an iterative double-dabble and drives a multiplexed 6-digit common-anode
// seven-segment display. Values above 999999 show six dashes and raise OVF.
// Optional build macro SEG_BLANK_LEADING_EN blanks zero digits above the most
// significant non-zero digit. Digit 0 and overflow dashes are never blanked.
//
// Handshake: VAL_LD is a single-cycle strobe. It is accepted only while the
// converter is idle; it is dropped without queueing while BUSY is high or in
// the completion cycle. The display registers and OVF update together on the
// same edge where BUSY falls.
module seg7_result_display #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [19:0] VAL,
    input  logic        VAL_LD,
    input  logic [5:0]  DP,
    output logic        BUSY,
    output logic        OVF,
    output logic [7:0]  LED_S,
    output logic [5:0]  LED_sel
);

    localparam int DIV_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIGIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Converter state, kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic [19:0]      bin_q;
    logic [23:0]      bcd_q;
    logic [4:0]       iter_q;
    logic             ovf_pend_q;
    logic [23:0]      disp_q;

    logic [23:0]      bcd_adj;
    logic [23:0]      bcd_shift;
    logic [19:0]      bin_shift;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;

    logic [3:0]       cur_nib;
    logic [5:0]       cur_onehot;
    logic             cur_dp;
    logic             cur_blank;
    logic [5:0]       lead_zero;
    logic [7:0]       seg_nxt;
    logic [5:0]       sel_nxt;

    // Active-low a..g pattern for one BCD digit; illegal codes go dark.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Converter state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Converter next-state: one extra CONV cycle after the 20th shift lines
    // the completion up with the documented BUSY timing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (VAL_LD) state_nxt = CONV;
            CONV:    if (iter_q == 5'd20) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        {bcd_shift, bin_shift} = {bcd_adj[22:0], bin_q, 1'b0};
    end

    // Converter datapath, display registers and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            BUSY       <= 1'b0;
            OVF        <= 1'b0;
        end else begin
            BUSY <= (state == CONV);
            case (state)
                IDLE: begin
                    if (VAL_LD) begin
                        bin_q      <= VAL;
                        bcd_q      <= '0;
                        iter_q     <= '0;
                        ovf_pend_q <= (VAL > 20'd999999);
                    end
                end
                CONV: begin
                    if (iter_q != 5'd20) begin
                        bcd_q  <= bcd_shift;
                        bin_q  <= bin_shift;
                        iter_q <= iter_q + 5'd1;
                    end
                end
                DONE: begin
                    disp_q <= bcd_q;
                    OVF    <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero map: a digit is blankable when it and all above are zero.
    always_comb begin
        lead_zero = '0;
`ifdef SEG_BLANK_LEADING_EN
        lead_zero[5] = (disp_q[23:20] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] && (disp_q[i*4 +: 4] == 4'd0);
        end
`endif
    end

    // Select the digit under the scan index and build the next LED drive.
    always_comb begin
        cur_nib    = 4'd0;
        cur_blank  = 1'b0;
        cur_onehot = 6'b000001;
        case (idx_q)
            3'd0:    begin cur_nib = disp_q[3:0];   cur_blank = lead_zero[0]; cur_onehot = 6'b000001; end
            3'd1:    begin cur_nib = disp_q[7:4];   cur_blank = lead_zero[1]; cur_onehot = 6'b000010; end
            3'd2:    begin cur_nib = disp_q[11:8];  cur_blank = lead_zero[2]; cur_onehot = 6'b000100; end
            3'd3:    begin cur_nib = disp_q[15:12]; cur_blank = lead_zero[3]; cur_onehot = 6'b001000; end
            3'd4:    begin cur_nib = disp_q[19:16]; cur_blank = lead_zero[4]; cur_onehot = 6'b010000; end
            3'd5:    begin cur_nib = disp_q[23:20]; cur_blank = lead_zero[5]; cur_onehot = 6'b100000; end
            default: begin cur_nib = 4'd0;          cur_blank = 1'b0;         cur_onehot = 6'b000001; end
        endcase
        cur_dp = |(DP & cur_onehot);

        sel_nxt = 6'h3F;
        seg_nxt = 8'hFF;
        if (div_q >= BLANK_END) begin
            sel_nxt    = ~cur_onehot;
            seg_nxt[7] = ~cur_dp;
            if (OVF)            seg_nxt[6:0] = 7'h3F;
            else if (cur_blank) seg_nxt[6:0] = 7'h7F;
            else                seg_nxt[6:0] = seg_code(cur_nib);
        end
    end

    // Scan divider, digit index and registered LED outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q   <= '0;
            idx_q   <= '0;
            LED_sel <= 6'h3F;
            LED_S   <= 8'hFF;
        end else begin
            LED_sel <= sel_nxt;
            LED_S   <= seg_nxt;
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule
